// File: rtl/c7bicu.sv
// ============================================================================
// c7bicu : IFU fetch responder, one-entry doubleword line buffer + mem port
// Rev 1.0
// ============================================================================
`default_nettype none

module c7bicu #(
    parameter bit LB_EN = 1'b1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        ifu_icu_req_ic1,
    input  logic [31:0] ifu_icu_addr_ic1,
    output logic        icu_ifu_ack_ic1,
    output logic        icu_ifu_data_valid_ic2,
    output logic [63:0] icu_ifu_data_ic2,
    input  logic        icu_inv,
    output logic        icu_mem_req,
    output logic [31:0] icu_mem_addr,
    input  logic        mem_icu_gnt,
    input  logic        mem_icu_rvalid,
    input  logic [63:0] mem_icu_rdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MREQ  = 2'd1,
        MWAIT = 2'd2
    } state_e;

    state_e      state_q;
    logic        dvalid_q;
    logic [63:0] data_q;
    logic        mem_req_q;
    logic [28:0] mem_tag_q;
    logic        lb_vld_q;
    logic [28:0] lb_tag_q;
    logic [63:0] lb_data_q;

    logic        w_ack;
    logic        w_hit;
    logic        w_unused_offset;

    // The offset bits never matter: everything is doubleword-granular.
    assign w_unused_offset = ^ifu_icu_addr_ic1[2:0];

    assign w_ack = ifu_icu_req_ic1 & (state_q == IDLE) & resetn;
    assign w_hit = LB_EN & lb_vld_q & ~icu_inv & (lb_tag_q == ifu_icu_addr_ic1[31:3]);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            dvalid_q  <= 1'b0;
            data_q    <= 64'd0;
            mem_req_q <= 1'b0;
            mem_tag_q <= 29'd0;
            lb_vld_q  <= 1'b0;
            lb_tag_q  <= 29'd0;
            lb_data_q <= 64'd0;
        end else begin
            dvalid_q <= 1'b0;
            if (icu_inv) begin
                lb_vld_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (w_ack) begin
                        if (w_hit) begin
                            data_q   <= lb_data_q;
                            dvalid_q <= 1'b1;
                        end else begin
                            mem_tag_q <= ifu_icu_addr_ic1[31:3];
                            mem_req_q <= 1'b1;
                            state_q   <= MREQ;
                        end
                    end
                end
                MREQ: begin
                    if (mem_icu_gnt) begin
                        mem_req_q <= 1'b0;
                        state_q   <= MWAIT;
                    end
                end
                MWAIT: begin
                    if (mem_icu_rvalid) begin
                        data_q   <= mem_icu_rdata;
                        dvalid_q <= 1'b1;
                        state_q  <= IDLE;
                        // A fill racing an invalidate still returns data but leaves the buffer empty.
                        if (LB_EN) begin
                            lb_tag_q  <= mem_tag_q;
                            lb_data_q <= mem_icu_rdata;
                            lb_vld_q  <= ~icu_inv;
                        end
                    end
                end
                default: begin
                    mem_req_q <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    assign icu_ifu_ack_ic1        = w_ack;
    assign icu_ifu_data_valid_ic2 = dvalid_q;
    assign icu_ifu_data_ic2       = data_q;
    assign icu_mem_req            = mem_req_q;
    assign icu_mem_addr           = {mem_tag_q, 3'b000};

endmodule

`default_nettype wire

// File: tb/tb_c7bicu.sv
// ============================================================================
// tb_c7bicu : scoreboard bench for c7bicu (buffered and unbuffered instances)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_c7bicu;

    logic        clk = 1'b0;
    logic        resetn;
    logic        req, inv, gnt, rvalid;
    logic [31:0] addr;
    logic [63:0] rdata;
    logic        ack, dv, mem_req;
    logic [63:0] data;
    logic [31:0] mem_addr;

    logic        req2, gnt2, rvalid2;
    logic [31:0] addr2;
    logic [63:0] rdata2;
    logic        ack2, dv2, mem_req2;
    logic [63:0] data2;
    logic [31:0] mem_addr2;

    int n_tests = 0;
    int n_fail  = 0;
    logic [63:0] sb[$];

    localparam logic [63:0] D1 = 64'h02800c0c_02800406;
    localparam logic [63:0] D2 = 64'hdeadbeef_00c0ffee;
    localparam logic [63:0] D3 = 64'h12345678_9abcdef0;
    localparam logic [63:0] D4 = 64'h0badf00d_cafe4444;
    localparam logic [63:0] D5 = 64'h55555555_aaaaaaaa;
    localparam logic [63:0] JUNK = 64'hffff0000_ffff0000;

    always #5 clk = ~clk;

    c7bicu #(.LB_EN(1'b1)) u_dut (
        .clk                    (clk),
        .resetn                 (resetn),
        .ifu_icu_req_ic1        (req),
        .ifu_icu_addr_ic1       (addr),
        .icu_ifu_ack_ic1        (ack),
        .icu_ifu_data_valid_ic2 (dv),
        .icu_ifu_data_ic2       (data),
        .icu_inv                (inv),
        .icu_mem_req            (mem_req),
        .icu_mem_addr           (mem_addr),
        .mem_icu_gnt            (gnt),
        .mem_icu_rvalid         (rvalid),
        .mem_icu_rdata          (rdata)
    );

    c7bicu #(.LB_EN(1'b0)) u_dut_nolb (
        .clk                    (clk),
        .resetn                 (resetn),
        .ifu_icu_req_ic1        (req2),
        .ifu_icu_addr_ic1       (addr2),
        .icu_ifu_ack_ic1        (ack2),
        .icu_ifu_data_valid_ic2 (dv2),
        .icu_ifu_data_ic2       (data2),
        .icu_inv                (1'b0),
        .icu_mem_req            (mem_req2),
        .icu_mem_addr           (mem_addr2),
        .mem_icu_gnt            (gnt2),
        .mem_icu_rvalid         (rvalid2),
        .mem_icu_rdata          (rdata2)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every data_valid pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (resetn === 1'b1 && dv === 1'b1) begin
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_data_valid: got data %h expected no pulse (t=%0t)", data, $time);
            end else begin
                logic [63:0] exp;
                exp = sb.pop_front();
                if (data !== exp) begin
                    n_fail++;
                    $display("FAIL sb_data: got %h expected %h (t=%0t)", data, exp, $time);
                end
            end
        end
    end

    // Called and returns at a falling edge; drives a full miss transaction.
    task automatic miss_fetch(input logic [31:0] a, input logic [63:0] d, input int gnt_dly,
                              input int rv_dly, input logic inv_at_rv, input logic spurious);
        logic [31:0] al;
        al = {a[31:3], 3'b000};
        req = 1'b1; addr = a;
        #1 chk("miss_ack", ack, 1);
        sb.push_back(d);
        @(negedge clk);
        chk("miss_mem_req", mem_req, 1);
        chk("miss_mem_addr", mem_addr, al);
        for (int i = 0; i < gnt_dly; i++) begin
            rvalid = spurious; rdata = JUNK;
            #1 chk("busy_no_ack", ack, 0);
            chk("stall_mem_req", mem_req, 1);
            chk("stall_mem_addr", mem_addr, al);
            @(negedge clk);
        end
        rvalid = 1'b0;
        gnt = 1'b1;
        @(negedge clk);
        gnt = 1'b0;
        chk("gnt_drops_req", mem_req, 0);
        for (int i = 1; i < rv_dly; i++) begin
            #1 chk("wait_no_ack", ack, 0);
            @(negedge clk);
        end
        req = 1'b0;
        rvalid = 1'b1; rdata = d; inv = inv_at_rv;
        @(negedge clk);
        rvalid = 1'b0; inv = 1'b0; rdata = JUNK;
    endtask

    task automatic hit_fetch(input logic [31:0] a, input logic [63:0] d);
        req = 1'b1; addr = a;
        #1 chk("hit_ack", ack, 1);
        sb.push_back(d);
        @(negedge clk);
        req = 1'b0;
        chk("hit_no_mem_req", mem_req, 0);
        chk("hit_dv", dv, 1);
    endtask

    initial begin
        resetn = 1'b0; req = 1'b1; addr = 32'h1c000000; inv = 1'b0;
        gnt = 1'b0; rvalid = 1'b0; rdata = 64'd0;
        req2 = 1'b0; addr2 = 32'd0; gnt2 = 1'b0; rvalid2 = 1'b0; rdata2 = 64'd0;

        // Reset, then accept immediately on release
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_ack", ack, 0);
            chk("rst_dv", dv, 0);
            chk("rst_data", data, 64'd0);
            chk("rst_mem_req", mem_req, 0);
            chk("rst_mem_addr", mem_addr, 32'd0);
        end
        resetn = 1'b1;
        #1 chk("release_ack", ack, 1);
        @(negedge clk);
        req = 1'b0;
        chk("release_mem_req", mem_req, 1);
        chk("release_mem_addr", mem_addr, 32'h1c000000);
        resetn = 1'b0;
        #1 chk("async_rst_mem_req", mem_req, 0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        // Cold miss, then back-to-back hits starting at R+1
        miss_fetch(32'h1c000004, D1, 1, 2, 1'b0, 1'b0);
        req = 1'b1; addr = 32'h1c000000;
        #1 chk("streak_ack0", ack, 1);
        sb.push_back(D1);
        @(negedge clk);
        addr = 32'h1c000004;
        #1 chk("streak_ack1", ack, 1);
        sb.push_back(D1);
        chk("streak_dv0", dv, 1);
        chk("streak_mem_req0", mem_req, 0);
        @(negedge clk);
        req = 1'b0;
        chk("streak_dv1", dv, 1);
        chk("streak_mem_req1", mem_req, 0);
        @(negedge clk);
        chk("streak_dv_drop", dv, 0);

        // Invalidate racing the fill: data returned, buffer left empty
        miss_fetch(32'h1c000040, D2, 0, 1, 1'b1, 1'b0);
        miss_fetch(32'h1c000040, D3, 0, 1, 1'b0, 1'b0);
        hit_fetch(32'h1c000044, D3);

        // Invalidate coinciding with a lookup forces a miss
        inv = 1'b1;
        req = 1'b1; addr = 32'h1c000040;
        #1 chk("inv_lookup_ack", ack, 1);
        sb.push_back(D3);
        @(negedge clk);
        inv = 1'b0;
        chk("inv_lookup_miss", mem_req, 1);
        req = 1'b0;
        gnt = 1'b1;
        @(negedge clk);
        gnt = 1'b0; rvalid = 1'b1; rdata = D3;
        @(negedge clk);
        rvalid = 1'b0;

        // Grant stalled 10 cycles with spurious rvalid
        miss_fetch(32'h1c000104, D4, 10, 3, 1'b0, 1'b1);
        @(negedge clk);

        // Reset during MWAIT drops the transaction and the buffer
        req = 1'b1; addr = 32'h1c000200;
        #1 chk("mwait_ack", ack, 1);
        @(negedge clk);
        req = 1'b0; gnt = 1'b1;
        @(negedge clk);
        gnt = 1'b0;
        chk("mwait_mem_req", mem_req, 0);
        resetn = 1'b0;
        #1 chk("mwait_rst_dv", dv, 0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        chk("post_rst_dv", dv, 0);
        miss_fetch(32'h1c000100, D5, 0, 1, 1'b0, 1'b0);

        // Unbuffered instance: repeated fetches always go to memory
        for (int k = 0; k < 2; k++) begin
            req2 = 1'b1; addr2 = 32'h1c00000c;
            #1 chk("nolb_ack", ack2, 1);
            @(negedge clk);
            req2 = 1'b0;
            chk("nolb_mem_req", mem_req2, 1);
            chk("nolb_mem_addr", mem_addr2, 32'h1c000008);
            gnt2 = 1'b1;
            @(negedge clk);
            gnt2 = 1'b0; rvalid2 = 1'b1; rdata2 = (k == 0) ? D1 : D2;
            @(negedge clk);
            rvalid2 = 1'b0;
            chk("nolb_dv", dv2, 1);
            chk("nolb_data", data2, (k == 0) ? D1 : D2);
        end

        repeat (3) @(negedge clk);
        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

`default_nettype wire
